// File: rtl/maze_game.sv
// maze_game: a grid of rooms the player walks with four edge-detected
// direction buttons, picking up the sword and then slaying the dragon
// (win), or meeting the dragon unarmed or running out of moves (dead).
module maze_game #(
  parameter int GRID_W      = 3,
  parameter int GRID_H      = 3,
  parameter int START_ROOM  = 0,
  parameter int SWORD_ROOM  = 2,
  parameter int DRAGON_ROOM = 8,
  parameter int MAX_MOVES   = 31,
  localparam int N  = GRID_W * GRID_H,
  localparam int IW = $clog2(N),
  localparam int MW = (MAX_MOVES < 1) ? 1 : $clog2(MAX_MOVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          n,
  input  logic          s,
  input  logic          e,
  input  logic          w,
  output logic [N-1:0]  room,
  output logic [IW-1:0] room_idx,
  output logic          sword,
  output logic          win,
  output logic          dead,
  output logic [MW-1:0] moves
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [3:0]    btn, btn_prev, press;
  logic          req, in_grid;
  int            cur_x, cur_y, nx, ny;
  logic [IW-1:0] target, room_idx_next;
  logic          sword_next;
  logic [MW-1:0] moves_inc, moves_next;

  // Button bundle ordered {n, s, e, w}; a press is a rising level.
  assign btn   = {n, s, e, w};
  assign press = btn & ~btn_prev;
  assign req   = $onehot(press);

  // Edge-detect history; loading the live level during reset means a
  // button held through reset release is not seen as a fresh press.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    btn_prev <= btn;
  end

  // Next-state, next-room, sword and move-counter decision.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_next    = state;
    room_idx_next = room_idx;
    sword_next    = sword;
    moves_next    = moves;
    cur_x         = int'(room_idx) % GRID_W;
    cur_y         = int'(room_idx) / GRID_W;
    nx            = cur_x;
    ny            = cur_y;
    case (press)
      4'b1000: ny = cur_y - 1;
      4'b0100: ny = cur_y + 1;
      4'b0010: nx = cur_x + 1;
      4'b0001: nx = cur_x - 1;
      default: ;
    endcase
    in_grid   = (nx >= 0) && (nx < GRID_W) && (ny >= 0) && (ny < GRID_H);
    target    = IW'(ny * GRID_W + nx);
    moves_inc = (moves == '1) ? moves : moves + 1'b1;

    case (state)
      PLAY: begin
        if (req && in_grid) begin
          room_idx_next = target;
          moves_next    = moves_inc;
          if (target == IW'(SWORD_ROOM)) sword_next = 1'b1;
          // Dragon outcome uses the sword held before this move and
          // outranks the move-limit timeout.
          if (target == IW'(DRAGON_ROOM))
            state_next = sword ? WIN : DEAD;
          else if (MAX_MOVES != 0 && moves_inc == MW'(MAX_MOVES))
            state_next = DEAD;
        end
      end
      WIN, DEAD: ;
      default: state_next = PLAY;
    endcase
  end

  // Game state registers; reset overrides any simultaneous request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PLAY;
      room_idx <= IW'(START_ROOM);
      sword    <= 1'b0;
      moves    <= '0;
    end else begin
      state    <= state_next;
      room_idx <= room_idx_next;
      sword    <= sword_next;
      moves    <= moves_next;
    end
  end

  // Outputs decoded from registers only.
  assign room = {{(N-1){1'b0}}, 1'b1} << room_idx;
  assign win  = (state == WIN);
  assign dead = (state == DEAD);

endmodule

// File: tb/tb_maze_game.sv
// Randomized and directed bench for maze_game: three instances (move
// limits 31, 3 and 4) share one stimulus stream and are compared every
// cycle against a coordinate-level model of the game rules.
module tb_maze_game;

  logic clk = 1'b0;
  logic reset, n, s, e, w;

  logic [8:0] r0, r1, r2;
  logic [3:0] i0, i1, i2;
  logic [4:0] m0;
  logic [1:0] m1;
  logic [2:0] m2;
  logic sw0, sw1, sw2, wn0, wn1, wn2, dd0, dd1, dd2;

  maze_game u0 (.clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .room(r0), .room_idx(i0), .sword(sw0), .win(wn0), .dead(dd0), .moves(m0));
  maze_game #(.MAX_MOVES(3)) u1 (.clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .room(r1), .room_idx(i1), .sword(sw1), .win(wn1), .dead(dd1), .moves(m1));
  maze_game #(.MAX_MOVES(4)) u2 (.clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .room(r2), .room_idx(i2), .sword(sw2), .win(wn2), .dead(dd2), .moves(m2));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: player position as (x, y), status 0=play 1=win 2=dead.
  localparam int GW = 3, GH = 3, START = 0, SWORD = 2, DRAGON = 8;
  localparam int MAXM [3] = '{31, 3, 4};
  localparam int SAT  [3] = '{31, 3, 7};
  int mx [3], my [3], msw [3], mst [3], mmv [3];
  logic [3:0] mprev;

  int a_idx [3], a_room [3], a_sw [3], a_win [3], a_dead [3], a_mv [3];
  always_comb begin
    a_idx  = '{int'(i0), int'(i1), int'(i2)};
    a_room = '{int'(r0), int'(r1), int'(r2)};
    a_sw   = '{int'(sw0), int'(sw1), int'(sw2)};
    a_win  = '{int'(wn0), int'(wn1), int'(wn2)};
    a_dead = '{int'(dd0), int'(dd1), int'(dd2)};
    a_mv   = '{int'(m0), int'(m1), int'(m2)};
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] b, input logic r);
    logic [3:0] pr;
    int dx, dy, tx, ty, had;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        mx[i] = START % GW; my[i] = START / GW;
        msw[i] = 0; mst[i] = 0; mmv[i] = 0;
      end
      mprev = b;
      return;
    end
    pr    = b & ~mprev;
    mprev = b;
    if ($countones(pr) != 1) return;
    dx = 0; dy = 0;
    if (pr[3]) dy = -1;
    if (pr[2]) dy = 1;
    if (pr[1]) dx = 1;
    if (pr[0]) dx = -1;
    for (int i = 0; i < 3; i++) begin
      tx = mx[i] + dx; ty = my[i] + dy;
      if (mst[i] == 0 && tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
        had = msw[i];
        mx[i] = tx; my[i] = ty;
        if (mmv[i] < SAT[i]) mmv[i]++;
        if (ty * GW + tx == SWORD) msw[i] = 1;
        if (ty * GW + tx == DRAGON) mst[i] = had ? 1 : 2;
        else if (MAXM[i] != 0 && mmv[i] == MAXM[i]) mst[i] = 2;
      end
    end
  endtask

  task automatic compare_all();
    int ri;
    for (int i = 0; i < 3; i++) begin
      ri = my[i] * GW + mx[i];
      check($sformatf("u%0d.room_idx", i), a_idx[i], ri);
      check($sformatf("u%0d.room", i), a_room[i], 1 << ri);
      check($sformatf("u%0d.sword", i), a_sw[i], msw[i]);
      check($sformatf("u%0d.win", i), a_win[i], int'(mst[i] == 1));
      check($sformatf("u%0d.dead", i), a_dead[i], int'(mst[i] == 2));
      check($sformatf("u%0d.moves", i), a_mv[i], mmv[i]);
    end
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 ns later.
  task automatic tick(input logic [3:0] b, input logic r);
    @(negedge clk);
    {n, s, e, w} = b;
    reset = r;
    @(posedge clk);
    model_step(b, r);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [3:0] b);
    tick(b, 1'b0);
    tick(4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
  endtask

  localparam logic [3:0] BN = 4'b1000, BS = 4'b0100, BE = 4'b0010, BW = 4'b0001;

  initial begin
    logic [3:0] b;
    logic       r;
    {n, s, e, w} = 4'b0000;
    reset = 1'b1;
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    check("reset.room_idx", int'(i0), START);
    check("reset.moves", int'(m0), 0);
    tick(4'b0000, 1'b0);

    // Wall at room 0, then a long hold yields one move.
    press(BN);
    check("wall.room_idx", int'(i0), 0);
    check("wall.moves", int'(m0), 0);
    for (int k = 0; k < 10; k++) tick(BE, 1'b0);
    tick(4'b0000, 1'b0);
    check("hold.room_idx", int'(i0), 1);
    check("hold.moves", int'(m0), 1);

    // Simultaneous presses are ignored.
    do_reset();
    press(BN | BE);
    check("simul.room_idx", int'(i0), 0);
    check("simul.moves", int'(m0), 0);
    press(BE);
    check("simul.after_e", int'(i0), 1);

    // Win path; limit-3 instance times out, limit-4 instance still wins.
    do_reset();
    press(BE);
    press(BE);
    check("win.sword_at_2", int'(sw0), 1);
    check("win.idx_2", int'(i0), 2);
    press(BS);
    press(BS);
    check("win.room_idx", int'(i0), 8);
    check("win.win", int'(wn0), 1);
    check("win.moves", int'(m0), 4);
    check("lim3.dead", int'(dd1), 1);
    check("lim3.room_idx", int'(i1), 5);
    check("lim4.win", int'(wn2), 1);
    check("lim4.moves", int'(m2), 4);
    press(BW);
    check("win.frozen_idx", int'(i0), 8);

    // Dragon without sword.
    do_reset();
    press(BS); press(BS); press(BE); press(BE);
    check("dragon.dead", int'(dd0), 1);
    check("dragon.sword", int'(sw0), 0);
    check("dragon.moves", int'(m0), 4);
    press(BN);
    check("dragon.frozen_idx", int'(i0), 8);
    check("dragon.frozen_moves", int'(m0), 4);

    // Timeout on the limit-3 instance.
    do_reset();
    press(BE); press(BW); press(BE);
    check("timeout.dead", int'(dd1), 1);
    check("timeout.room_idx", int'(i1), 1);
    check("timeout.moves", int'(m1), 3);

    // Reset mid-game with e held through release.
    do_reset();
    press(BE); press(BE);
    tick(BE, 1'b0);
    tick(BE, 1'b1);
    tick(BE, 1'b1);
    check("midrst.room_idx", int'(i0), 0);
    check("midrst.sword", int'(sw0), 0);
    check("midrst.moves", int'(m0), 0);
    for (int k = 0; k < 3; k++) tick(BE, 1'b0);
    check("midrst.held_no_move", int'(i0), 0);
    tick(4'b0000, 1'b0);
    tick(BE, 1'b0);
    check("midrst.repress", int'(i0), 1);

    // Random play with occasional reset, model-checked every cycle.
    do_reset();
    b = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0: b = 4'b0000;
        1: b = 4'b0001 << $urandom_range(0, 3);
        2: ;
        default: b = 4'($urandom_range(0, 15));
      endcase
      tick(b, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
